// File: rtl/griffin_scheduler.sv
// Round-robin front end that time-shares one griffin permutation core between
// N_REQ requesters, with a watchdog that aborts and resets a hung core.
module griffin_scheduler #(
  parameter int N_BITS     = 254,
  parameter int STATE_SIZE = 3,
  parameter int N_REQ      = 4,
  parameter int ID_W       = $clog2(N_REQ),
  parameter int TIMEOUT    = 1023
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [N_REQ-1:0]                            req_valid_i,
  input  logic [N_REQ-1:0][STATE_SIZE-1:0][N_BITS-1:0] req_state_i,
  output logic [N_REQ-1:0]                            req_ready_o,
  output logic                                        resp_valid_o,
  input  logic                                        resp_ready_i,
  output logic [ID_W-1:0]                             resp_id_o,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]           resp_state_o,
  output logic                                        resp_error_o,
  output logic                                        core_reset_o,
  output logic                                        core_enable_o,
  output logic [STATE_SIZE-1:0][N_BITS-1:0]           core_in_o,
  input  logic [STATE_SIZE-1:0][N_BITS-1:0]           core_out_i,
  input  logic                                        core_done_i,
  output logic                                        busy_o,
  output logic [1:0]                                  state_o
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]  RR_INIT  = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]    N_REQ_W  = (ID_W + 1)'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                             state_q;
  logic [ID_W-1:0]                    rr_ptr_q;
  logic [ID_W-1:0]                    id_q;
  logic [CNT_W-1:0]                   wd_cnt_q;
  logic                               resp_valid_q;
  logic                               resp_error_q;
  logic [STATE_SIZE-1:0][N_BITS-1:0]  resp_state_q;
  logic [STATE_SIZE-1:0][N_BITS-1:0]  core_in_q;
  logic                               core_enable_q;
  logic                               core_reset_q;

  logic                               grant_vld;
  logic [ID_W-1:0]                    grant_idx;
  logic [ID_W:0]                      cand;

  // Search starts just past the last served requester, so it drops to lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!grant_vld && req_valid_i[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  // Valid/ready: a request moves when req_valid[g] & req_ready[g], a response
  // when resp_valid & resp_ready; valid never depends on ready and the offered
  // response is frozen until it moves. req_ready is a one-cycle grant strobe.
  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && grant_vld && !reset_i) req_ready_o[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= RR_INIT;
      id_q          <= '0;
      wd_cnt_q      <= '0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_state_q  <= '0;
      core_in_q     <= '0;
      core_enable_q <= 1'b0;
      core_reset_q  <= 1'b1;
    end else begin
      core_enable_q <= 1'b0;
      core_reset_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            core_in_q     <= req_state_i[grant_idx];
            id_q          <= grant_idx;
            rr_ptr_q      <= grant_idx;
            core_enable_q <= 1'b1;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the final watchdog cycle still counts as success.
          if (core_done_i) begin
            resp_state_q <= core_out_i;
            resp_error_q <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (wd_cnt_q == CNT_LAST) begin
            resp_state_q <= '0;
            resp_error_q <= 1'b1;
            resp_valid_q <= 1'b1;
            core_reset_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid_o  = resp_valid_q;
  assign resp_id_o     = id_q;
  assign resp_state_o  = resp_state_q;
  assign resp_error_o  = resp_error_q;
  assign core_reset_o  = core_reset_q;
  assign core_enable_o = core_enable_q;
  assign core_in_o     = core_in_q;
  assign busy_o        = (state_q != S_IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_griffin_scheduler.sv
// Bench for griffin_scheduler: a latency-programmable core model, a
// transaction-level reference checked every cycle, and directed scenarios.
module tb_griffin_scheduler;

  localparam int NB = 254;
  localparam int SS = 3;
  localparam int NR = 4;
  localparam int IW = 2;
  localparam int TO = 48;

  typedef logic [SS-1:0][NB-1:0] st_t;
  typedef logic [NR-1:0][SS-1:0][NB-1:0] req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_i = 1'b1;
  logic [NR-1:0] req_valid = '0;
  req_t          req_state = '0;
  logic [NR-1:0] req_ready;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [IW-1:0] resp_id;
  st_t           resp_state;
  logic          resp_error;
  logic          core_reset;
  logic          core_enable;
  st_t           core_in;
  st_t           core_out = '0;
  logic          core_done = 1'b0;
  logic          busy;
  logic [1:0]    dbg_state;

  griffin_scheduler #(
    .N_BITS(NB), .STATE_SIZE(SS), .N_REQ(NR), .ID_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_state_i(req_state), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
    .resp_state_o(resp_state), .resp_error_o(resp_error),
    .core_reset_o(core_reset), .core_enable_o(core_enable), .core_in_o(core_in),
    .core_out_i(core_out), .core_done_i(core_done),
    .busy_o(busy), .state_o(dbg_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_force = -1;
  bit stray_en  = 1'b0;
  int core_lat  = 1;

  task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic st_t perm(st_t x);
    st_t y;
    logic [NB-1:0] k;
    for (int w = 0; w < SS; w++) begin
      k = NB'(w + 1);
      y[w] = x[w] ^ (k << 12);
    end
    return y;
  endfunction

  function automatic st_t rand_st();
    st_t y;
    logic [255:0] t;
    for (int w = 0; w < SS; w++) begin
      t = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      y[w] = t[NB-1:0];
    end
    return y;
  endfunction

  function automatic req_t rand_req();
    req_t v;
    for (int r = 0; r < NR; r++) v[r] = rand_st();
    return v;
  endfunction

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 5) return $urandom_range(1, 8);
    if (r < 7) return TO;
    if (r == 7) return 1000;
    if (r == 8) return TO - 1;
    return $urandom_range(9, TO + 3);
  endfunction

  function automatic int rr_pick(logic [NR-1:0] v, int last);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int oh_idx(logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Core model: done arrives core_lat cycles after the enable pulse.
  st_t core_cap;
  int  core_start = 0;
  bit  core_pend  = 1'b0;
  always @(posedge clk) begin
    #1;
    if (reset_i || core_reset) core_pend = 1'b0;
    if (core_enable) begin
      core_pend  = 1'b1;
      core_start = cyc;
      core_cap   = core_in;
      core_lat   = (lat_force >= 0) ? lat_force : pick_lat();
    end
    if (core_pend && cyc == core_start + core_lat) begin
      core_done = 1'b1;
      core_out  = perm(core_cap);
      core_pend = 1'b0;
    end else begin
      core_done = stray_en && !core_pend && ($urandom_range(0, 7) == 0);
      core_out  = rand_st();
    end
  end

  // Reference: one transaction in flight; its response time follows from the
  // core latency or the watchdog, whichever comes first.
  bit            m_busy = 1'b0;
  bit            m_rknown = 1'b0;
  bit            m_err = 1'b0;
  bit            m_first = 1'b1;
  int            m_t = 0;
  int            m_r = 0;
  int            m_last = NR - 1;
  logic [IW-1:0] m_id = '0;
  st_t           m_state = '0;
  st_t           m_rstate = '0;

  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    int g;
    bit exp_rv;
    if (reset_i) begin
      m_busy = 1'b0; m_rknown = 1'b0; m_last = NR - 1; m_first = 1'b1;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        g = rr_pick(req_valid, m_last);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      if (m_busy && cyc == m_t + 1) begin
        m_rknown = 1'b1;
        if (core_lat <= TO) begin
          m_r = m_t + 2 + core_lat; m_err = 1'b0; m_rstate = perm(m_state);
        end else begin
          m_r = m_t + 2 + TO; m_err = 1'b1; m_rstate = '0;
        end
      end
      exp_rv = m_busy && m_rknown && (cyc >= m_r);
      chk("req_ready", req_ready, exp_rdy);
      chk("core_enable", core_enable, m_busy && cyc == m_t + 1);
      chk("busy", busy, m_busy && cyc > m_t);
      if (m_busy && cyc > m_t) chk("core_in", core_in, m_state);
      chk("resp_valid", resp_valid, exp_rv);
      if (exp_rv) begin
        chk("resp_id", resp_id, m_id);
        chk("resp_state", resp_state, m_rstate);
        chk("resp_error", resp_error, m_err);
      end
      chk("core_reset", core_reset, m_first || (exp_rv && m_err && cyc == m_r));
      m_first = 1'b0;
      if (exp_rv && resp_ready) begin
        m_busy = 1'b0; m_rknown = 1'b0;
      end else if (g >= 0) begin
        m_busy = 1'b1; m_rknown = 1'b0; m_t = cyc;
        m_id = IW'(g); m_state = req_state[g]; m_last = g;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 300 && (busy || resp_valid); i++) tick();
    chk("idle_bound", i < 300, 1'b1);
  endtask

  task automatic wait_rv(output int rc);
    rc = -1;
    for (int i = 0; i < TO + 40; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rc = cyc;
        break;
      end
    end
    chk("resp_bound", rc >= 0, 1'b1);
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int   order[8];
    int   n, t0, en_cnt, en_cyc, rv_cyc, cr_cnt, xfers;
    st_t  lit, bp_in, in_st;

    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;

    // Fairness: everyone requesting from reset.
    lat_force = 3;
    req_valid = 4'hF;
    n = 0;
    for (int i = 0; i < 400 && n < 8; i++) begin
      req_state = rand_req();
      @(negedge clk);
      if (req_ready != '0) begin
        order[n] = oh_idx(req_ready);
        n++;
      end
      tick();
    end
    chk("fair_count", n, 8);
    for (int k = 0; k < 8; k++) chk("fair_order", order[k], k % 4);
    req_valid = '0;
    wait_idle();

    // Single request, 40-cycle core.
    lat_force = 40;
    req_state = rand_req();
    req_state[2][0] = 254'd1;
    req_state[2][1] = 254'd2;
    req_state[2][2] = 254'd3;
    req_valid = 4'b0100;
    @(negedge clk);
    t0 = cyc;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    en_cnt = 0; en_cyc = -1; rv_cyc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_enable) begin
        en_cnt++;
        en_cyc = cyc;
      end
      if (resp_valid) begin
        rv_cyc = cyc;
        break;
      end
    end
    lit[0] = 254'h1001;
    lit[1] = 254'h2002;
    lit[2] = 254'h3003;
    chk("single_en_cnt", en_cnt, 1);
    chk("single_en_cyc", en_cyc, t0 + 1);
    chk("single_rv_cyc", rv_cyc, t0 + 42);
    chk("single_id", resp_id, 2'd2);
    chk("single_state", resp_state, lit);
    chk("single_err", resp_error, 1'b0);
    tick();
    wait_idle();

    // Backpressure: hold resp_ready low for 10 response cycles.
    lat_force = 5;
    resp_ready = 1'b0;
    req_state = rand_req();
    bp_in = req_state[0];
    req_valid = 4'b0001;
    @(negedge clk);
    chk("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'hF;
    wait_rv(rv_cyc);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_state", resp_state, perm(bp_in));
      chk("bp_hold_id", resp_id, 2'd0);
      chk("bp_no_grant", req_ready, 4'b0000);
      tick();
      if (i == 9) resp_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_xfer_valid", resp_valid, 1'b1);
    chk("bp_xfer_nogrant", req_ready, 4'b0000);
    tick();
    @(negedge clk);
    chk("bp_after_valid", resp_valid, 1'b0);
    chk("bp_next_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle();

    // Watchdog abort: core never answers.
    lat_force = 1000;
    req_state = rand_req();
    req_valid = 4'b1000;
    @(negedge clk);
    t0 = cyc;
    chk("to_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    rv_cyc = -1; cr_cnt = 0;
    for (int i = 0; i < TO + 30; i++) begin
      @(negedge clk);
      if (core_reset) cr_cnt++;
      if (resp_valid) begin
        rv_cyc = cyc;
        break;
      end
    end
    chk("to_rv_cyc", rv_cyc, t0 + TO + 2);
    chk("to_err", resp_error, 1'b1);
    chk("to_state", resp_state, 768'd0);
    chk("to_core_reset_cnt", cr_cnt, 1);
    tick();
    @(negedge clk);
    chk("to_core_reset_end", core_reset, 1'b0);
    tick();
    wait_idle();

    // Normal request right after the abort.
    lat_force = 7;
    req_state = rand_req();
    in_st = req_state[0];
    req_valid = 4'b0001;
    @(negedge clk);
    chk("post_to_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    wait_rv(rv_cyc);
    chk("post_to_err", resp_error, 1'b0);
    chk("post_to_state", resp_state, perm(in_st));
    tick();
    wait_idle();

    // Done on the very cycle the watchdog expires.
    lat_force = TO;
    req_state = rand_req();
    in_st = req_state[1];
    req_valid = 4'b0010;
    @(negedge clk);
    t0 = cyc;
    chk("sim_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_rv(rv_cyc);
    chk("sim_rv_cyc", rv_cyc, t0 + TO + 2);
    chk("sim_err", resp_error, 1'b0);
    chk("sim_state", resp_state, perm(in_st));
    tick();
    wait_idle();

    // Asynchronous reset in the middle of a wait.
    lat_force = 1000;
    req_state = rand_req();
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rst_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    repeat (6) tick();
    #2;
    reset_i = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_id", resp_id, 2'd0);
    chk("rst_resp_state", resp_state, 768'd0);
    chk("rst_resp_error", resp_error, 1'b0);
    chk("rst_core_enable", core_enable, 1'b0);
    chk("rst_core_in", core_in, 768'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_core_reset", core_reset, 1'b1);
    lat_force = 4;
    repeat (2) tick();
    reset_i = 1'b0;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("rst_first_grant", req_ready, 4'b0001);
    chk("rst_core_reset_hold", core_reset, 1'b1);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rst_core_reset_drop", core_reset, 1'b0);
    tick();
    wait_idle();

    // Randomized traffic against the reference.
    lat_force = -1;
    stray_en = 1'b1;
    xfers = 0;
    for (int i = 0; i < 30000 && xfers < 80; i++) begin
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : NR'($urandom_range(0, 15));
      req_state = rand_req();
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (resp_valid && resp_ready) xfers++;
      tick();
    end
    chk("rand_xfers", xfers, 80);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/griffin_scheduler.md
Name: griffin_scheduler

Overview:
- Round-robin scheduler that shares one `griffin` permutation core between N_REQ independent requesters.
- Accepts a hash request (STATE_SIZE-word input state) from one requester at a time and drives the core's enable and input-state lines.
- Waits for core `done`, then returns the output state with the requester ID over a backpressured response channel.
- Includes a watchdog that aborts a hung permutation and resets the core.

Parameters:
- N_BITS, 254, field element width.
- STATE_SIZE, 3, words per Griffin state.
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), requester ID width.
- TIMEOUT, 1023, maximum cycles to wait for core done before abort (1..65535).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_state  in  [N_REQ][STATE_SIZE][N_BITS]  per-requester input state.
- req_ready  out  N_REQ  one-hot accept; high only in the cycle a request is granted.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  ID of the requester being answered.
- resp_state  out  [STATE_SIZE][N_BITS]  permutation output.
- resp_error  out  1  1 = watchdog abort; resp_state is all zeros.
- core_reset  out  1  synchronous reset to the core.
- core_enable  out  1  start pulse to the core.
- core_in  out  [STATE_SIZE][N_BITS]  core input state.
- core_out  in  [STATE_SIZE][N_BITS]  core output state.
- core_done  in  1  core completion.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE, rr_ptr=N_REQ-1.
  - req_ready=0, resp_valid=0, resp_id=0, resp_state=0, resp_error=0, core_enable=0, core_in=0, busy=0.
  - core_reset=1 during reset and for 1 cycle after deassertion.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first valid index searching from rr_ptr+1 upward, with modulo N_REQ wrap.
  - In the same cycle: req_ready[g]=1 (combinational), latch core_in<=req_state[g], latch id<=g, set rr_ptr<=g, go to ISSUE.
- ISSUE: core_enable=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - core_in is held stable throughout.
  - On core_done=1: latch resp_state<=core_out, resp_error<=0, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT: resp_state<=0, resp_error<=1, core_reset=1 for one cycle, go to RESP.
  - core_done and timeout in the same cycle: core_done wins (no error).
- RESP:
  - resp_valid=1, resp_id=latched id.
  - Outputs are held stable until resp_ready=1. The transfer completes in that cycle and the block goes to IDLE.
  - No new grant is made in the transfer cycle.
- Handshakes and latency:
  - Request transfer = req_valid[g] & req_ready[g].
  - Response transfer = resp_valid & resp_ready.
  - Grant at cycle T gives core_enable at T+1. core_done at cycle D gives resp_valid at D+1.
  - Minimum gap between consecutive grants is 4 cycles.
- Requester rules:
  - Dropping req_valid without being granted is allowed.
  - Requests are never queued; only the registered core_in copy is kept.
  - A requester that was just served has the lowest priority next time.
- core_done outside WAIT is ignored.
- The block assumes the core returns to its initial state after asserting done.

Test Plan:
- Single request: requester 2 with state {1,2,3}, core model done after 40 cycles with output {A,B,C} -> req_ready=4'b0100 at T, core_enable at T+1 only, resp_valid at T+42, resp_id=2, resp_state={A,B,C}, resp_error=0.
- Fairness: all four req_valid held high for 8 transactions from reset -> grant order 0,1,2,3,0,1,2,3.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid -> resp_* stable for 10 cycles, no new req_ready, transfer on the 11th cycle.
- Timeout: TIMEOUT=20, core never asserts done -> resp_valid 21 cycles after core_enable, resp_error=1, resp_state=0, core_reset pulses once, next request is served normally.
- Simultaneous done and timeout at count 20 -> resp_error=0, resp_state=core_out.
- Reset asserted mid-WAIT -> all outputs reach reset values without a clock edge; after release, a request from 0 is granted first and core_reset is high for 1 cycle.
